// File: rtl/cpu_pkg.sv
// cpu_pkg: shared encodings and widths for the multicycle CPU.
//   PCSrc encodings (PC_SRC_*), PC-unit state encodings (ST_*) and ADDR_W.
package cpu_pkg;
    localparam int ADDR_W = 32;
    typedef enum logic [1:0] {
        PC_SRC_SEQ = 2'b00,
        PC_SRC_BR  = 2'b01,
        PC_SRC_JMP = 2'b10,
        PC_SRC_REG = 2'b11
    } pc_src_t;
    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_HALT  = 2'b01,
        ST_FAULT = 2'b10
    } pc_state_t;
endpackage

// File: rtl/pc_next_mux.sv
// pc_next_mux: combinational next-PC select, including jump-address formation.
//   in : pc_plus4, tgt_q, src (PCSrc), branch_taken, jump_index, reg_target
//   out: next_pc
module pc_next_mux
    import cpu_pkg::*;
(
    input  logic [ADDR_W-1:0] pc_plus4,
    input  logic [ADDR_W-1:0] tgt_q,
    input  logic [1:0]        src,
    input  logic              branch_taken,
    input  logic [25:0]       jump_index,
    input  logic [ADDR_W-1:0] reg_target,
    output logic [ADDR_W-1:0] next_pc
);
    logic [ADDR_W-1:0] jump_pc;
    assign jump_pc = {pc_plus4[31:28], jump_index, 2'b00};
    always_comb begin
        next_pc = (src == PC_SRC_REG) ? reg_target :
                  (src == PC_SRC_JMP) ? jump_pc :
                  (src == PC_SRC_BR && branch_taken) ? tgt_q : pc_plus4;
    end
endmodule

// File: rtl/pc_next_unit.sv
// pc_next_unit: PC register, branch-target latch, next-PC commit and halt/fault tracking.
//   in : CLK, RST (sync, active-low), PCWre, PCSrc, branch_taken, tgt_load,
//        branch_target, jump_index, reg_target, halt
//   out: pc, pc_plus4 (combinational), tgt_q, state, update_cnt, fault, fault_addr
//   Optional: PC_ALIGN_CHECK_EN rejects misaligned next_pc and enters FAULT.
module pc_next_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        PCWre,
    input  logic [1:0]  PCSrc,
    input  logic        branch_taken,
    input  logic        tgt_load,
    input  logic [31:0] branch_target,
    input  logic [25:0] jump_index,
    input  logic [31:0] reg_target,
    input  logic        halt,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] tgt_q,
    output logic [1:0]  state,
    output logic [31:0] update_cnt,
    output logic        fault,
    output logic [31:0] fault_addr
);
    logic [ADDR_W-1:0] pc_q, pc_d, target_q, target_d, cnt_q, cnt_d, next_pc;
    pc_state_t         state_q, state_d;
    logic [ADDR_W-1:0] fault_addr_q, fault_addr_d;

    assign pc_plus4 = pc_q + 32'd4;

    // The mux sees the registered target, so a same-cycle tgt_load only affects later branches.
    pc_next_mux u_mux (
        .pc_plus4    (pc_plus4),
        .tgt_q       (target_q),
        .src         (PCSrc),
        .branch_taken(branch_taken),
        .jump_index  (jump_index),
        .reg_target  (reg_target),
        .next_pc     (next_pc)
    );

    always_comb begin
        pc_d         = pc_q;
        cnt_d        = cnt_q;
        state_d      = state_q;
        fault_addr_d = fault_addr_q;
        target_d     = tgt_load ? branch_target : target_q;
        if (state_q == ST_RUN) begin
            if (halt) begin
                state_d = ST_HALT;
            end else if (PCWre) begin
`ifdef PC_ALIGN_CHECK_EN
                if (next_pc[1:0] != 2'b00) begin
                    state_d      = ST_FAULT;
                    fault_addr_d = next_pc;
                end else
`endif
                begin
                    pc_d  = next_pc;
                    cnt_d = cnt_q + 32'd1;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            pc_q         <= RESET_PC;
            target_q     <= '0;
            cnt_q        <= '0;
            state_q      <= ST_RUN;
            fault_addr_q <= '0;
        end else begin
            pc_q         <= pc_d;
            target_q     <= target_d;
            cnt_q        <= cnt_d;
            state_q      <= state_d;
            fault_addr_q <= fault_addr_d;
        end
    end

    assign pc         = pc_q;
    assign tgt_q      = target_q;
    assign update_cnt = cnt_q;
    assign state      = state_q;
`ifdef PC_ALIGN_CHECK_EN
    assign fault      = (state_q == ST_FAULT);
    assign fault_addr = fault_addr_q;
`else
    assign fault      = 1'b0;
    assign fault_addr = '0;
`endif
endmodule

// File: tb/tb_pc_next_unit.sv
// tb_pc_next_unit: scoreboard bench for pc_next_unit with a behavioural reference model.
module tb_pc_next_unit;
    localparam logic [31:0] RPC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        rst_n, we, bt, tl, hl;
    logic [1:0]  src;
    logic [31:0] btgt, rt;
    logic [25:0] ji;
    logic [31:0] pc, pc_plus4, tgt_q, update_cnt, fault_addr;
    logic [1:0]  state;
    logic        fault;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] tgt;
        logic [1:0]  st;
        logic [31:0] cnt;
        logic [31:0] fa;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    logic [31:0] m_pc, m_tgt, m_cnt, m_fa;
    logic [1:0]  m_st;

    always #5 clk = ~clk;

    pc_next_unit #(.RESET_PC(RPC)) dut (
        .CLK(clk), .RST(rst_n), .PCWre(we), .PCSrc(src), .branch_taken(bt),
        .tgt_load(tl), .branch_target(btgt), .jump_index(ji), .reg_target(rt),
        .halt(hl), .pc(pc), .pc_plus4(pc_plus4), .tgt_q(tgt_q), .state(state),
        .update_cnt(update_cnt), .fault(fault), .fault_addr(fault_addr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_next(input logic [1:0] s, input logic b,
                                               input logic [25:0] j, input logic [31:0] r);
        logic [31:0] seq;
        seq = m_pc + 32'd4;
        case (s)
            2'd0:    return seq;
            2'd1:    return b ? m_tgt : seq;
            2'd2:    return (seq & 32'hF000_0000) | ({6'd0, j} << 2);
            default: return r;
        endcase
    endfunction

    task automatic step(input logic r, input logic w, input logic [1:0] s, input logic b,
                        input logic t, input logic [31:0] bta, input logic [25:0] j,
                        input logic [31:0] rg, input logic h);
        logic [31:0] nxt;
        exp_t e;
        rst_n = r; we = w; src = s; bt = b; tl = t; btgt = bta; ji = j; rt = rg; hl = h;
        @(posedge clk);
        nxt = model_next(s, b, j, rg);
        if (!r) begin
            m_pc = RPC; m_tgt = 0; m_cnt = 0; m_fa = 0; m_st = 2'd0;
        end else begin
            if (m_st == 2'd0) begin
                if (h) m_st = 2'd1;
                else if (w) begin
`ifdef PC_ALIGN_CHECK_EN
                    if (nxt % 4 != 0) begin m_st = 2'd2; m_fa = nxt; end
                    else begin m_pc = nxt; m_cnt = m_cnt + 1; end
`else
                    m_pc = nxt; m_cnt = m_cnt + 1;
`endif
                end
            end
            if (t) m_tgt = bta;
        end
        e.pc = m_pc; e.tgt = m_tgt; e.st = m_st; e.cnt = m_cnt; e.fa = m_fa;
        q.push_back(e);
        #1;
    endtask

    task automatic go(input logic w, input logic [1:0] s, input logic b, input logic [31:0] rg);
        step(1'b1, w, s, b, 1'b0, 32'd0, 26'd0, rg, 1'b0);
    endtask

    // Monitor: the DUT presents a fresh registered state every cycle; compare on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("pc", pc, e.pc);
                chk("pc_plus4", pc_plus4, e.pc + 32'd4);
                chk("tgt_q", tgt_q, e.tgt);
                chk("state", {30'd0, state}, {30'd0, e.st});
                chk("update_cnt", update_cnt, e.cnt);
                chk("fault", {31'd0, fault}, {31'd0, e.st == 2'd2});
                chk("fault_addr", fault_addr, e.fa);
            end
        end
    end

    initial begin
        m_pc = 0; m_tgt = 0; m_cnt = 0; m_fa = 0; m_st = 0;
        step(1'b0, 1'b1, 2'd3, 1'b0, 1'b1, 32'h55, 26'd0, 32'h1234, 1'b0);
        step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'd0, 26'd0, 32'd0, 1'b0);
        chk("reset_pc", pc, 32'h3000);
        chk("reset_tgt", tgt_q, 32'h0);
        repeat (3) go(1'b1, 2'd0, 1'b0, 32'd0);
        chk("seq_pc", pc, 32'h300C);
        chk("seq_cnt", update_cnt, 32'd3);
        go(1'b1, 2'd3, 1'b0, 32'h100);
        step(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 32'h140, 26'd0, 32'd0, 1'b0);
        go(1'b1, 2'd1, 1'b1, 32'd0);
        chk("br_taken", pc, 32'h140);
        go(1'b1, 2'd3, 1'b0, 32'h100);
        go(1'b1, 2'd1, 1'b0, 32'd0);
        chk("br_not_taken", pc, 32'h104);
        step(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 32'h200, 26'd0, 32'd0, 1'b0);
        step(1'b1, 1'b1, 2'd1, 1'b1, 1'b1, 32'h300, 26'd0, 32'd0, 1'b0);
        chk("br_old_tgt", pc, 32'h200);
        chk("br_new_tgt", tgt_q, 32'h300);
        go(1'b1, 2'd3, 1'b0, 32'h4000_0010);
        step(1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 32'd0, 26'h0000040, 32'd0, 1'b0);
        chk("jump", pc, 32'h4000_0100);
        go(1'b1, 2'd3, 1'b0, 32'h20);
        chk("jr", pc, 32'h20);
        go(1'b1, 2'd3, 1'b0, 32'h22);
`ifdef PC_ALIGN_CHECK_EN
        chk("misalign_pc", pc, 32'h20);
        chk("misalign_fault", {31'd0, fault}, 32'd1);
        chk("misalign_addr", fault_addr, 32'h22);
`else
        chk("misalign_pc", pc, 32'h22);
        chk("misalign_fault", {31'd0, fault}, 32'd0);
`endif
        step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'd0, 26'd0, 32'd0, 1'b0);
        go(1'b1, 2'd3, 1'b0, 32'hFFFF_FFFC);
        go(1'b1, 2'd0, 1'b0, 32'd0);
        chk("wrap", pc, 32'h0);
        step(1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 32'd0, 26'd0, 32'd0, 1'b1);
        chk("halt_pc", pc, 32'h0);
        chk("halt_state", {30'd0, state}, 32'd1);
        go(1'b1, 2'd3, 1'b0, 32'h88);
        chk("halt_frozen", pc, 32'h0);
        step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'd0, 26'd0, 32'd0, 1'b0);
        chk("unhalt_pc", pc, RPC);
        chk("unhalt_state", {30'd0, state}, 32'd0);
        for (int i = 0; i < 500; i++) begin
            logic [31:0] r;
            r = $urandom;
            if ($urandom_range(7) != 0) r[1:0] = 2'b00;
            step($urandom_range(49) != 0, $urandom_range(3) != 0, 2'($urandom_range(3)),
                 1'($urandom_range(1)), $urandom_range(2) == 0, $urandom,
                 26'($urandom), r, $urandom_range(39) == 0);
        end
        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_next_unit.md
# pc_next_unit

Program-counter register and next-PC selector for the multicycle CPU. It holds the architectural PC and latches the branch target produced by the branch-target adder during decode. On each control-unit write strobe it commits one of four next-PC sources. It also tracks halt and fault state, and provides the PC and PC+4 that feed instruction fetch and the branch-target adder.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  reset; synchronous, active-low.
- PCWre  input  1  PC write strobe from the control unit.
- PCSrc  input  2  next-PC select: 00 = PC+4, 01 = branch, 10 = jump, 11 = register.
- branch_taken  input  1  branch condition resolved by the ALU; used only when PCSrc = 01.
- tgt_load  input  1  latch branch_target into the target register.
- branch_target  input  32  output of the branch-target adder.
- jump_index  input  26  instr[25:0] for j/jal.
- reg_target  input  32  rs value for jr.
- halt  input  1  halt request from the control unit.
- pc  output  32  current PC, registered.
- pc_plus4  output  32  pc + 4, combinational from pc.
- tgt_q  output  32  latched branch target, registered.
- state  output  2  00 = RUN, 01 = HALTED, 10 = FAULT.
- update_cnt  output  32  count of committed PC writes.
- fault  output  1  high while in FAULT.
- fault_addr  output  32  rejected next-PC value.

## Operation
- next_pc is selected by PCSrc:
  - 00: pc_plus4.
  - 01: tgt_q if branch_taken, else pc_plus4.
  - 10: {pc_plus4[31:28], jump_index, 2'b00}.
  - 11: reg_target.
- All adders are 32-bit modulo 2^32; pc_plus4 wraps from 32'hFFFF_FFFC to 0.
- tgt_load = 1 sets tgt_q <= branch_target. This is independent of state; it is ignored only under reset.
- FSM:
  - RUN:
    - halt = 1: go to HALTED. The PC is not written, even if PCWre = 1.
    - Otherwise, PCWre = 1 with an accepted next_pc: pc <= next_pc and update_cnt <= update_cnt + 1 (wraps).
  - HALTED: pc, update_cnt and fault_addr are frozen; only reset exits.
  - FAULT: entered only with PC_ALIGN_CHECK_EN defined. pc, update_cnt and fault_addr are frozen; only reset exits.
- PCWre = 0 holds pc in every state.
- Reset (RST = 0 at an edge) has priority over all inputs and sets:
  - pc = RESET_PC
  - tgt_q = 0
  - state = RUN
  - update_cnt = 0
  - fault_addr = 0
  - fault = 0

## Timing
- PC write latency is 1 cycle: pc shows next_pc in the cycle after the edge that sampled PCWre = 1.
- pc_plus4 follows pc combinationally, in the same cycle.
- If tgt_load and PCWre with PCSrc = 01 occur in the same cycle, the branch uses the old tgt_q; the new target is visible from the next cycle.
- If halt and PCWre occur in the same cycle, halt wins; state reads HALTED in the next cycle.
- Deasserting reset mid-operation: the first edge with RST = 1 evaluates inputs normally against the reset values.
- Outputs are glitch-free registered values, except pc_plus4.

## Configuration
- PC_ALIGN_CHECK_EN defined:
  - A PCWre in RUN with next_pc[1:0] != 2'b00 and halt = 0 is rejected.
  - pc is unchanged, update_cnt is unchanged, fault_addr <= next_pc, and state goes to FAULT (fault = 1).
- PC_ALIGN_CHECK_EN undefined:
  - next_pc is written unchanged, including its low bits.
  - The FAULT state does not exist.
  - fault is tied to 0 and fault_addr is tied to 0.

## Structure
- Shared package cpu_pkg holds:
  - PCSrc encodings PC_SRC_SEQ, PC_SRC_BR, PC_SRC_JMP, PC_SRC_REG.
  - State encodings ST_RUN, ST_HALT, ST_FAULT.
  - The width constant ADDR_W = 32.
- One natural sub-module, pc_next_mux: the combinational next_pc select, including jump-address formation.
- The state register, pc, tgt_q and counter stay in the top module.

## Test plan
- Reset with RESET_PC = 32'h0000_3000, then three PCWre pulses with PCSrc = 00 -> pc = 3004, 3008, 300C; update_cnt = 3.
- Branch case, starting at pc = 32'h100:
  - tgt_load with branch_target = 32'h140, then PCWre with PCSrc = 01 and branch_taken = 1 -> pc = 32'h140.
  - Repeating with branch_taken = 0 -> pc = 32'h104.
- Same-cycle load and branch: tgt_q = 32'h200, tgt_load with branch_target = 32'h300 and PCWre/PCSrc = 01/taken in one cycle -> pc = 32'h200, tgt_q = 32'h300.
- Jump and register:
  - At pc = 32'h4000_0010, PCSrc = 10 with jump_index = 26'h0000040 -> pc = 32'h4000_0100.
  - PCSrc = 11 with reg_target = 32'h0000_0020 -> pc = 32'h20.
- Halt: halt and PCWre in the same cycle -> pc unchanged, state = HALTED; further PCWre are ignored; RST low for one edge -> pc = RESET_PC, state = RUN.
- With PC_ALIGN_CHECK_EN: PCSrc = 11 with reg_target = 32'h0000_0022 -> pc unchanged, fault = 1, fault_addr = 32'h22, update_cnt unchanged. Without the macro, the same stimulus gives pc = 32'h22 and fault = 0.
